// File: rtl/wb_pkg.sv
// Shared widths, arbiter state encoding and parameter defaults for the writeback path.
package wb_pkg;
  localparam int XLEN             = 32;
  localparam int REG_ADDR_W       = 5;
  localparam int FIFO_DEPTH_DEF   = 4;
  localparam int STARVE_LIMIT_DEF = 3;

  typedef enum logic {
    ALU_PRI   = 1'b0,
    LSU_FORCE = 1'b1
  } arb_state_e;
endpackage

// File: rtl/wb_fifo.sv
// Load-writeback queue: circular buffer with occupancy count and a per-entry rd tap for hazard probing.
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 37,
  parameter int TAP_W = 5
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_push,
  input  logic [WIDTH-1:0]              i_data,
  input  logic                          i_pop,
  output logic [WIDTH-1:0]              o_data,
  output logic                          o_full,
  output logic                          o_empty,
  output logic [$clog2(DEPTH):0]        o_count,
  output logic [DEPTH-1:0][TAP_W-1:0]   o_tap_rd,
  output logic [DEPTH-1:0]              o_tap_vld
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Pointers are AW bits wide, so wrap modulo DEPTH falls out of the arithmetic.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // An entry is live when its distance from the read pointer is below the occupancy.
  for (genvar g = 0; g < DEPTH; g++) begin : g_tap
    logic [AW-1:0] w_off;
    assign w_off        = AW'(g) - r_rd_ptr;
    assign o_tap_vld[g] = ({1'b0, w_off} < r_count);
    assign o_tap_rd[g]  = r_mem[g][WIDTH-1 -: TAP_W];
  end
endmodule

// File: rtl/writeback_arbiter.sv
// Merges ALU and queued load writebacks onto one register-file write port, with
// starvation forcing for the load queue and source-register hazard probing.
//
//   state     | meaning
//   ----------+--------------------------------------------------------------
//   ALU_PRI   | ALU request wins; queue head drains when the ALU is idle
//   LSU_FORCE | ALU stalled for one cycle while the queue head is committed
module writeback_arbiter
  import wb_pkg::*;
#(
  parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  input  logic                  iALU_VALID,
  input  logic [REG_ADDR_W-1:0] iALU_RD,
  input  logic [XLEN-1:0]       iALU_DATA,
  output logic                  oALU_READY,
  input  logic                  iLSU_VALID,
  input  logic [REG_ADDR_W-1:0] iLSU_RD,
  input  logic [XLEN-1:0]       iLSU_DATA,
  output logic                  oLSU_READY,
  output logic                  oWB_WE,
  output logic [REG_ADDR_W-1:0] oWB_RD,
  output logic [XLEN-1:0]       oWB_DATA,
  input  logic [REG_ADDR_W-1:0] iRS1,
  input  logic [REG_ADDR_W-1:0] iRS2,
  output logic                  oRS1_PENDING,
  output logic                  oRS2_PENDING
);
  localparam int ENTRY_W = REG_ADDR_W + XLEN;
  localparam int CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam int QCNT_W  = $clog2(FIFO_DEPTH) + 1;

  arb_state_e                            r_state;
  arb_state_e                            w_state_nxt;
  logic [CNT_W-1:0]                      r_starve_cnt;
  logic [CNT_W-1:0]                      w_cnt_nxt;
  logic                                  w_alu_grant;
  logic                                  w_pop;
  logic                                  w_push;
  logic                                  w_full;
  logic                                  w_empty;
  logic [QCNT_W-1:0]                     w_count;
  logic                                  w_q_busy;
  logic [ENTRY_W-1:0]                    w_head;
  logic [FIFO_DEPTH-1:0][REG_ADDR_W-1:0] w_tap_rd;
  logic [FIFO_DEPTH-1:0]                 w_tap_vld;
  logic                                  w_sel_v;
  logic [REG_ADDR_W-1:0]                 w_sel_rd;
  logic [XLEN-1:0]                       w_sel_data;
  logic                                  r_wb_we;
  logic [REG_ADDR_W-1:0]                 r_wb_rd;
  logic [XLEN-1:0]                       r_wb_data;

  // rd = 0 loads are accepted but never occupy a slot.
  assign w_push     = iLSU_VALID && !w_full && (iLSU_RD != '0);
  assign oLSU_READY = !w_full;
  assign w_q_busy   = (w_count != '0);

  wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W),
    .TAP_W (REG_ADDR_W)
  ) u_fifo (
    .i_clk     (iCLK),
    .i_rst_n   (iRST),
    .i_push    (w_push),
    .i_data    ({iLSU_RD, iLSU_DATA}),
    .i_pop     (w_pop),
    .o_data    (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (w_count),
    .o_tap_rd  (w_tap_rd),
    .o_tap_vld (w_tap_vld)
  );

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_state      <= ALU_PRI;
      r_starve_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    oALU_READY  = 1'b1;
    w_alu_grant = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      ALU_PRI: begin
        if (iALU_VALID) w_alu_grant = 1'b1;
        else if (!w_empty) w_pop = 1'b1;
      end
      LSU_FORCE: begin
        oALU_READY  = 1'b0;
        w_pop       = !w_empty;
        w_state_nxt = ALU_PRI;
      end
      default: w_state_nxt = ALU_PRI;
    endcase

    if (w_pop || !w_q_busy) w_cnt_nxt = '0;
    else if (w_alu_grant)   w_cnt_nxt = r_starve_cnt + 1'b1;
    else                    w_cnt_nxt = r_starve_cnt;

    if (r_state == ALU_PRI && w_cnt_nxt == CNT_W'(STARVE_LIMIT)) w_state_nxt = LSU_FORCE;
  end

  assign w_sel_v    = w_alu_grant || w_pop;
  assign w_sel_rd   = w_alu_grant ? iALU_RD   : w_head[ENTRY_W-1 -: REG_ADDR_W];
  assign w_sel_data = w_alu_grant ? iALU_DATA : w_head[XLEN-1:0];

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_wb_we   <= 1'b0;
      r_wb_rd   <= '0;
      r_wb_data <= '0;
    end else begin
      r_wb_we <= w_sel_v && (w_sel_rd != '0);
      if (w_sel_v) begin
        r_wb_rd   <= w_sel_rd;
        r_wb_data <= w_sel_data;
      end
    end
  end

  assign oWB_WE   = r_wb_we;
  assign oWB_RD   = r_wb_rd;
  assign oWB_DATA = r_wb_data;

  // A register stays pending through the cycle its write is on the port.
  always_comb begin
    oRS1_PENDING = 1'b0;
    oRS2_PENDING = 1'b0;
    if (iRS1 != '0 && r_wb_we && r_wb_rd == iRS1) oRS1_PENDING = 1'b1;
    if (iRS2 != '0 && r_wb_we && r_wb_rd == iRS2) oRS2_PENDING = 1'b1;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (iRS1 != '0 && w_tap_vld[i] && w_tap_rd[i] == iRS1) oRS1_PENDING = 1'b1;
      if (iRS2 != '0 && w_tap_vld[i] && w_tap_rd[i] == iRS2) oRS2_PENDING = 1'b1;
    end
  end
endmodule
